// File: rtl/thresholding_cfg_sequencer_pkg.sv
// Shared types and helpers for the threshold configuration sequencer:
// sequencer states, config address width and address field packing.
package thresholding_cfg_pkg;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } seq_state_e;

    // Address width: {cf, pe, t}; a field collapses to zero bits when its count is 1.
    function automatic int cfg_a_bits(input int n, input int c, input int pe);
        return $clog2(c / pe) + $clog2(pe) + n;
    endfunction

    // Register width for a counter over 'count' values; never narrower than one bit.
    function automatic int field_bits(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

    function automatic logic [31:0] pack_addr(input logic [31:0] cf, input logic [31:0] pe,
                                              input logic [31:0] t, input int n,
                                              input int pe_cnt);
        return (cf << ($clog2(pe_cnt) + n)) | (pe << n) | t;
    endfunction

endpackage

// File: rtl/thresholding_cfg_sequencer_if.sv
// Bundle of threshold stream, host config, kernel config and data-gating
// signals seen by the sequencer; master is the sequencer's view.
interface thresholding_cfg_sequencer_if #(
    parameter int K      = 8,
    parameter int A_BITS = 4
);
    localparam int TD_W = ((K + 7) / 8) * 8;

    logic              s_axis_thr_tvalid;
    logic              s_axis_thr_tready;
    logic [TD_W-1:0]   s_axis_thr_tdata;

    logic              h_en;
    logic              h_we;
    logic [A_BITS-1:0] h_a;
    logic [K-1:0]      h_d;
    logic              h_rack;
    logic [K-1:0]      h_q;

    logic              cfg_en;
    logic              cfg_we;
    logic [A_BITS-1:0] cfg_a;
    logic [K-1:0]      cfg_d;
    logic              cfg_rack;
    logic [K-1:0]      cfg_q;

    logic              s_ivld;
    logic              s_irdy;
    logic              k_ivld;
    logic              k_irdy;
    logic              k_ovld;
    logic              k_ordy;

    logic              loaded;

    modport master (
        input  s_axis_thr_tvalid, s_axis_thr_tdata,
        output s_axis_thr_tready,
        input  h_en, h_we, h_a, h_d,
        output h_rack, h_q,
        output cfg_en, cfg_we, cfg_a, cfg_d,
        input  cfg_rack, cfg_q,
        input  s_ivld, k_irdy, k_ovld, k_ordy,
        output s_irdy, k_ivld,
        output loaded
    );

    modport slave (
        output s_axis_thr_tvalid, s_axis_thr_tdata,
        input  s_axis_thr_tready,
        output h_en, h_we, h_a, h_d,
        input  h_rack, h_q,
        input  cfg_en, cfg_we, cfg_a, cfg_d,
        output cfg_rack, cfg_q,
        output s_ivld, k_irdy, k_ovld, k_ordy,
        input  s_irdy, k_ivld,
        input  loaded
    );

endinterface

// File: rtl/thresholding_cfg_sequencer.sv
// Loads threshold sets from a stream into a thresholding kernel's config port,
// holding off and draining the data path around each reload; host has priority.
module thresholding_cfg_sequencer
    import thresholding_cfg_pkg::*;
#(
    parameter int N             = 2,
    parameter int K             = 8,
    parameter int C             = 1,
    parameter int PE            = 1,
    parameter int INIT_LOAD     = 1,
    parameter int INFLIGHT_BITS = 8
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
    thresholding_cfg_sequencer_if.master bus
);

    localparam int CF         = C / PE;
    localparam int T_LAST     = (1 << N) - 2;
    localparam int TD_W       = ((K + 7) / 8) * 8;
    localparam int CFG_A_BITS = cfg_a_bits(N, C, PE);
    localparam int PE_W       = field_bits(PE);
    localparam int CF_W       = field_bits(CF);

    seq_state_e               state_q, state_d;
    logic [N-1:0]             t_q, t_d;
    logic [PE_W-1:0]          pe_q, pe_d;
    logic [CF_W-1:0]          cf_q, cf_d;
    logic [INFLIGHT_BITS-1:0] inflight_q, inflight_d;
    logic                     loaded_q, loaded_d;

    logic                  in_run;
    logic                  thr_ready;
    logic                  thr_hs;
    logic                  last_word;
    logic                  beat_in;
    logic                  beat_out;
    logic [CFG_A_BITS-1:0] load_addr;

    assign in_run    = (state_q == ST_RUN);
    // Host access steals the config port, so the loader simply stalls that cycle.
    assign thr_ready = ap_rst_n & (state_q == ST_LOAD) & ~bus.h_en;
    assign thr_hs    = thr_ready & bus.s_axis_thr_tvalid;
    assign last_word = (t_q == N'(T_LAST)) && (pe_q == PE_W'(PE - 1)) && (cf_q == CF_W'(CF - 1));
    assign beat_in   = bus.s_ivld & bus.k_irdy & in_run;
    assign beat_out  = bus.k_ovld & bus.k_ordy;
    assign load_addr = CFG_A_BITS'(pack_addr(32'(cf_q), 32'(pe_q), 32'(t_q), N, PE));

    assign bus.s_axis_thr_tready = thr_ready;
    assign bus.h_rack            = bus.cfg_rack;
    assign bus.h_q               = bus.cfg_q;
    assign bus.k_ivld            = bus.s_ivld & in_run;
    assign bus.s_irdy            = bus.k_irdy & in_run;
    assign bus.loaded            = loaded_q;

    always_comb begin
        bus.cfg_en = 1'b0;
        bus.cfg_we = 1'b0;
        bus.cfg_a  = '0;
        bus.cfg_d  = '0;
        if (bus.h_en) begin
            bus.cfg_en = 1'b1;
            bus.cfg_we = bus.h_we;
            bus.cfg_a  = bus.h_a;
            bus.cfg_d  = bus.h_d;
        end else if (thr_hs) begin
            bus.cfg_en = 1'b1;
            bus.cfg_we = 1'b1;
            bus.cfg_a  = load_addr;
            bus.cfg_d  = bus.s_axis_thr_tdata[K-1:0];
        end
    end

    always_comb begin
        inflight_d = inflight_q;
        if (beat_in && !beat_out) begin
            inflight_d = inflight_q + INFLIGHT_BITS'(1);
        end else if (!beat_in && beat_out) begin
            inflight_d = inflight_q - INFLIGHT_BITS'(1);
        end
    end

    always_comb begin
        state_d  = state_q;
        t_d      = t_q;
        pe_d     = pe_q;
        cf_d     = cf_q;
        loaded_d = loaded_q;
        case (state_q)
            ST_LOAD: begin
                if (thr_hs) begin
                    if (last_word) begin
                        t_d      = '0;
                        pe_d     = '0;
                        cf_d     = '0;
                        loaded_d = 1'b1;
                        state_d  = ST_RUN;
                    end else if (t_q != N'(T_LAST)) begin
                        t_d = t_q + N'(1);
                    end else begin
                        // t skips the all-ones slot; pe then cf carry.
                        t_d = '0;
                        if (pe_q != PE_W'(PE - 1)) begin
                            pe_d = pe_q + PE_W'(1);
                        end else begin
                            pe_d = '0;
                            cf_d = cf_q + CF_W'(1);
                        end
                    end
                end
            end
            ST_RUN: begin
                if (bus.s_axis_thr_tvalid) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Exit as soon as the last in-flight beat leaves.
                if (inflight_d == '0) begin
                    state_d = ST_LOAD;
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_q    <= (INIT_LOAD != 0) ? ST_LOAD : ST_RUN;
            t_q        <= '0;
            pe_q       <= '0;
            cf_q       <= '0;
            inflight_q <= '0;
            loaded_q   <= (INIT_LOAD == 0);
        end else begin
            state_q    <= state_d;
            t_q        <= t_d;
            pe_q       <= pe_d;
            cf_q       <= cf_d;
            inflight_q <= inflight_d;
            loaded_q   <= loaded_d;
        end
    end

    generate
        if (TD_W > K) begin : g_pad
            logic unused_tdata_pad;
            assign unused_tdata_pad = ^bus.s_axis_thr_tdata[TD_W-1:K];
        end
    endgenerate

    a_inflight_overflow : assert property (@(posedge ap_clk) disable iff (!ap_rst_n)
        !(beat_in && !beat_out && (&inflight_q)));
    a_inflight_underflow : assert property (@(posedge ap_clk) disable iff (!ap_rst_n)
        !(beat_out && !beat_in && (inflight_q == '0)));

endmodule

// File: tb/tb_thresholding_cfg_sequencer.sv
// Directed + randomized bench for the threshold config sequencer, checked
// cycle by cycle against a behavioural model of load/run/drain.
module tb_thresholding_cfg_sequencer;

    localparam int N     = 2;
    localparam int K     = 8;
    localparam int C     = 4;
    localparam int PE    = 2;
    localparam int TPC   = (1 << N) - 1;
    localparam int WORDS = C * TPC;
    localparam int M_LOAD  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    thresholding_cfg_sequencer_if #(.K(K), .A_BITS(4)) bus ();

    thresholding_cfg_sequencer #(
        .N(N), .K(K), .C(C), .PE(PE), .INIT_LOAD(1), .INFLIGHT_BITS(8)
    ) dut (
        .ap_clk   (clk),
        .ap_rst_n (rst_n),
        .bus      (bus)
    );

    int tests = 0;
    int fails = 0;
    int m_mode, m_idx, m_infl;
    bit m_loaded;

    // Word i belongs to channel i/TPC at threshold slot i%TPC.
    function automatic int exp_addr(input int i);
        int c;
        c = i / TPC;
        return (c / PE) * PE * (1 << N) + (c % PE) * (1 << N) + (i % TPC);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.s_axis_thr_tvalid = 1'b0;
        bus.s_axis_thr_tdata  = '0;
        bus.h_en = 1'b0;
        bus.h_we = 1'b0;
        bus.h_a  = '0;
        bus.h_d  = '0;
        bus.cfg_rack = 1'b0;
        bus.cfg_q    = '0;
        bus.s_ivld = 1'b0;
        bus.k_irdy = 1'b0;
        bus.k_ovld = 1'b0;
        bus.k_ordy = 1'b0;
    endtask

    // Inputs are already driven; check outputs, advance the model, move to next cycle.
    task automatic tick();
        bit tr_exp, hs, run;
        #1;
        tr_exp = (m_mode == M_LOAD) && !bus.h_en && rst_n;
        hs     = tr_exp && bus.s_axis_thr_tvalid;
        run    = (m_mode == M_RUN);
        chk("tready", 32'(bus.s_axis_thr_tready), 32'(tr_exp));
        chk("cfg_en", 32'(bus.cfg_en), 32'(bus.h_en || hs));
        if (bus.h_en) begin
            chk("host_we", 32'(bus.cfg_we), 32'(bus.h_we));
            chk("host_a", 32'(bus.cfg_a), 32'(bus.h_a));
            chk("host_d", 32'(bus.cfg_d), 32'(bus.h_d));
        end else if (hs) begin
            chk("load_we", 32'(bus.cfg_we), 32'd1);
            chk("load_a", 32'(bus.cfg_a), 32'(exp_addr(m_idx)));
            chk("load_d", 32'(bus.cfg_d), 32'(bus.s_axis_thr_tdata));
            $display("[TB] %0t load word %0d a=%0d d=%02h", $time, m_idx, bus.cfg_a, bus.cfg_d);
        end
        chk("h_rack", 32'(bus.h_rack), 32'(bus.cfg_rack));
        chk("h_q", 32'(bus.h_q), 32'(bus.cfg_q));
        chk("k_ivld", 32'(bus.k_ivld), 32'(bus.s_ivld && run));
        chk("s_irdy", 32'(bus.s_irdy), 32'(bus.k_irdy && run));
        chk("loaded", 32'(bus.loaded), 32'(m_loaded));
        if (!rst_n) begin
            m_mode = M_LOAD; m_idx = 0; m_infl = 0; m_loaded = 1'b0;
        end else begin
            if (run && bus.s_ivld && bus.k_irdy) m_infl++;
            if (bus.k_ovld && bus.k_ordy) m_infl--;
            case (m_mode)
                M_LOAD: if (hs) begin
                    m_idx++;
                    if (m_idx == WORDS) begin
                        m_idx = 0; m_mode = M_RUN; m_loaded = 1'b1;
                    end
                end
                M_RUN:   if (bus.s_axis_thr_tvalid) m_mode = M_DRAIN;
                default: if (m_infl == 0) m_mode = M_LOAD;
            endcase
        end
        @(negedge clk);
    endtask

    // Random loader traffic with host interference until 'limit' words of the set are in.
    task automatic random_load(input int limit);
        int g;
        g = 0;
        while (m_mode == M_LOAD && m_idx < limit && g < 500) begin
            idle();
            bus.s_axis_thr_tvalid = ($urandom % 4) != 0;
            bus.s_axis_thr_tdata  = 8'($urandom);
            bus.h_en = ($urandom % 4) == 0;
            bus.h_we = 1'($urandom);
            bus.h_a  = 4'($urandom);
            bus.h_d  = 8'($urandom);
            bus.s_ivld = 1'($urandom);
            bus.k_irdy = 1'($urandom);
            tick();
            g++;
        end
        if (g >= 500) chk("load_bound", 32'(g), 32'd0);
    endtask

    task automatic run_random(input int n);
        for (int i = 0; i < n; i++) begin
            idle();
            bus.s_ivld = 1'($urandom);
            bus.k_irdy = 1'($urandom);
            bus.k_ovld = (m_infl > 0) ? 1'($urandom) : 1'b0;
            bus.k_ordy = 1'($urandom);
            bus.h_en   = ($urandom % 4) == 0;
            bus.h_we   = 1'($urandom);
            bus.h_a    = 4'($urandom);
            bus.h_d    = 8'($urandom);
            bus.cfg_rack = 1'($urandom);
            bus.cfg_q    = 8'($urandom);
            tick();
        end
    endtask

    // Request a reload, then retire in-flight beats until the loader takes over.
    task automatic reload_drain();
        int g;
        idle();
        bus.s_axis_thr_tvalid = 1'b1;
        tick();
        g = 0;
        while (m_mode == M_DRAIN && g < 200) begin
            idle();
            bus.s_ivld = 1'b1;
            bus.k_irdy = 1'b1;
            bus.k_ovld = (m_infl > 0) ? 1'($urandom) : 1'b0;
            bus.k_ordy = 1'b1;
            tick();
            g++;
        end
        if (g >= 200) chk("drain_bound", 32'(g), 32'd0);
        idle();
        tick();
    endtask

    initial begin
        bit host_done;
        int g;
        idle();
        m_mode = M_LOAD; m_idx = 0; m_infl = 0; m_loaded = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        tick();
        tick();
        rst_n = 1'b1;

        // Directed first load with a host write stealing the port when word 3 is offered.
        host_done = 1'b0;
        g = 0;
        while (m_mode == M_LOAD && g < 100) begin
            idle();
            bus.s_axis_thr_tvalid = 1'b1;
            bus.s_axis_thr_tdata  = 8'(8'h10 + m_idx);
            bus.s_ivld = 1'b1;
            bus.k_irdy = 1'b1;
            if (m_idx == 3 && !host_done) begin
                bus.h_en = 1'b1; bus.h_we = 1'b1; bus.h_a = 4'd5; bus.h_d = 8'hEE;
                host_done = 1'b1;
            end
            tick();
            g++;
        end
        if (g >= 100) chk("load1_bound", 32'(g), 32'd0);

        // Host read in RUN, kernel acks two cycles later.
        idle(); bus.h_en = 1'b1; bus.h_a = 4'd3; tick();
        idle(); tick();
        idle(); bus.cfg_rack = 1'b1; bus.cfg_q = 8'h5A; tick();

        // One beat in, a same-cycle in/out beat, two more in: three in flight.
        idle(); bus.s_ivld = 1'b1; bus.k_irdy = 1'b1; tick();
        idle(); bus.s_ivld = 1'b1; bus.k_irdy = 1'b1; bus.k_ovld = 1'b1; bus.k_ordy = 1'b1; tick();
        idle(); bus.s_ivld = 1'b1; bus.k_irdy = 1'b0; tick();
        idle(); bus.s_ivld = 1'b1; bus.k_irdy = 1'b1; tick();
        idle(); bus.s_ivld = 1'b1; bus.k_irdy = 1'b1; tick();
        reload_drain();

        // Partial load, reset mid-set, then a full randomized set.
        random_load(8);
        idle(); rst_n = 1'b0; tick(); tick();
        rst_n = 1'b1;
        random_load(WORDS);
        run_random(40);
        reload_drain();
        random_load(WORDS);
        run_random(10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/thresholding_cfg_sequencer.md
Name: thresholding_cfg_sequencer

Overview:
- Sequences threshold (re)loading for a thresholding kernel instance.
- Streams threshold words from an AXI-Stream into the kernel config port, in channel-major order, with address translation.
- Holds off the kernel input stream, then drains in-flight data before each reload, so no inference ever sees a partial threshold set.
- Shares the config port with the AXI-Lite host path (from axi4lite_if); the host has absolute priority.

Parameters:
- N, none, output precision; 2^N-1 thresholds per channel.
- K, none, threshold precision.
- C, 1, channels.
- PE, 1, parallelism; C = k*PE.
- INIT_LOAD, 1, 1: come out of reset in LOAD; 0: come out of reset in RUN (thresholds preinitialised).
- INFLIGHT_BITS, 8, width of the in-flight beat counter.
- CFG_A_BITS, derived = $clog2(C/PE)+$clog2(PE)+N, config word address width.

Ports:
- ap_clk  in  1  clock.
- ap_rst_n  in  1  synchronous active-low reset.
- s_axis_thr_tvalid  in  1  threshold stream valid.
- s_axis_thr_tready  out  1  threshold stream ready.
- s_axis_thr_tdata  in  ((K+7)/8)*8  threshold word; low K bits used.
- h_en, h_we  in  1  host config strobe / write enable.
- h_a  in  CFG_A_BITS  host word address.
- h_d  in  K  host write data.
- h_rack  out  1  host read ack.
- h_q  out  K  host read data.
- cfg_en, cfg_we  out  1  kernel config strobe / write enable.
- cfg_a  out  CFG_A_BITS  kernel address.
- cfg_d  out  K  kernel write data.
- cfg_rack  in  1  kernel read ack.
- cfg_q  in  K  kernel read data.
- s_ivld  in  1  upstream data valid.
- s_irdy  out  1  upstream data ready.
- k_ivld  out  1  kernel input valid.
- k_irdy  in  1  kernel input ready.
- k_ovld, k_ordy  in  1  kernel output handshake (monitored only).
- loaded  out  1  sticky: at least one complete set written since reset.

Behaviour:
- States: LOAD, RUN, DRAIN. Reset state: LOAD if INIT_LOAD, else RUN.
- Reset values: loaded = !INIT_LOAD; counters = 0; s_axis_thr_tready = 0.
- Output gating: k_ivld = s_ivld & (state==RUN); s_irdy = k_irdy & (state==RUN); both combinational.
- In-flight counter: +1 on k_ivld&k_irdy, -1 on k_ovld&k_ordy; both in the same cycle leaves it unchanged. Overflow or underflow is an assertion error.
- RUN -> DRAIN when s_axis_thr_tvalid=1.
- DRAIN -> LOAD when the in-flight counter = 0. Input is already gated, so no new beats enter.
- LOAD: s_axis_thr_tready = !h_en.
  - Each thr beat issues a single-cycle write: cfg_en=1, cfg_we=1, cfg_d=tdata[K-1:0].
  - Write is combinational from the handshake; latency 0.
- LOAD address counters: t (0..2^N-2, fastest), pe (0..PE-1), cf (0..C/PE-1); channel c = cf*PE+pe.
  - cfg_a = {cf,pe,t}; the pe and cf fields are absent when PE=1 or CF=1 respectively.
  - t wraps to 0 after 2^N-2, never reaching 2^N-1.
- LOAD -> RUN on the handshake of word C*(2^N-1)-1. That cycle: all counters clear and loaded is set.
- Host path: whenever h_en=1, cfg_* = h_*, regardless of state. Loader tready=0 in that cycle (stall, no word lost).
- Read path: h_rack = cfg_rack, h_q = cfg_q. The loader never reads.
- RUN/DRAIN: host writes pass through unchanged. Coherence of host writes is the host's responsibility.
- Reset mid-LOAD: counters clear, return to the reset state; partial set discarded, loaded follows its reset value.

Decomposition:
- Package thresholding_cfg_pkg: state enum (LOAD/RUN/DRAIN); function computing CFG_A_BITS; address field pack function.
- No sub-module: single module, about 200 lines.

Test Plan (N=2, K=8, C=4, PE=2, INIT_LOAD=1):
- After reset, stream 12 words 0x10..0x1B, continuous valid:
  - Writes go to addresses 0,1,2,4,5,6,8,9,10,12,13,14.
  - loaded rises in the cycle after word 11.
  - k_ivld stays 0 throughout.
- Host h_en=1 (write, a=5) on the cycle word 3 is offered:
  - cfg_a=5 from the host in that cycle, tready=0.
  - Word 3 is written to address 4 the next cycle.
- RUN with 3 beats accepted and none emitted, then thr_tvalid rises:
  - State DRAIN, s_irdy=0.
  - After 3 output handshakes, the state becomes LOAD in the next cycle.
- Same-cycle input and output beat with counter at 1: counter stays 1; no DRAIN exit.
- Assert reset after word 7, then stream 12 words: addresses restart at 0; loaded=0 until completion.
- Host read in RUN with cfg_rack two cycles later, cfg_q=0x5A: h_rack=1, h_q=0x5A in the same cycle.
